// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared types and constants for the SPART receive path
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int SAMPLE_W       = $clog2(OVERSAMPLE_DEF);
  localparam int BITCNT_W       = $clog2(DATA_BITS_DEF + 1);

endpackage

// File: rtl/spart_sync2.sv
// rtl/spart_sync2.sv - two-flop synchroniser with configurable reset value
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART receiver, 8N1 by default, 8E1 when SPART_RX_PARITY_EN is defined
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state_q, state_d;
  logic [SMP_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 frame_done;

  spart_sync2 #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rxd_s)
  );

`ifdef SPART_RX_PARITY_EN
  logic parity_bit_q, parity_bit_d;
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_done   = 1'b0;
`ifdef SPART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
`endif
    if (rx_enable) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end
        START: begin
          if (sample_cnt_q == SMP_MID) begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
            state_d      = rxd_s ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        DATA: begin
          // Power-of-two oversample lets the counter wrap on its own.
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_q == SMP_LAST) begin
            shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef SPART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef SPART_RX_PARITY_EN
        PARITY: begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_q == SMP_LAST) begin
            parity_bit_d = rxd_s;
            state_d      = STOP;
          end
        end
`endif
        STOP: begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_q == SMP_LAST) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame completion takes priority over a coincident rd_ack.
  always_comb begin
    rx_data_d     = rx_data_q;
    framing_err_d = framing_err_q;
    rda_d         = rda_q & ~rd_ack;
    overrun_err_d = overrun_err_q & ~rd_ack;
`ifdef SPART_RX_PARITY_EN
    parity_err_d  = parity_err_q;
`endif
    if (frame_done) begin
      rx_data_d     = shift_q;
      framing_err_d = ~rxd_s;
      overrun_err_d = overrun_err_q | (rda_q & ~rd_ack);
      rda_d         = 1'b1;
`ifdef SPART_RX_PARITY_EN
      parity_err_d  = (^shift_q) ^ parity_bit_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rda_q         <= rda_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

`ifdef SPART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != IDLE);

endmodule
